mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported, synchronous-read 32-bit memory between three requesters: the instruction-fetch path, the load/store data path, and a program loader used to fill memory before and between runs. It replaces the dual-port memory interface in front of the CPU datapath. Each access is sequenced by a three-state FSM. The instruction and data paths stall on `busy`/`done` until their access completes.

## Interface
Parameters:
- `ADDR_W`, 10, word address width (matches memory depth of 1024 words)
- `DATA_W`, 32, data width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ld_req`  in  1  loader request; held until `ld_done`
- `ld_we`  in  1  loader write enable; 0 = read (no data returned)
- `ld_addr`  in  ADDR_W  loader address
- `ld_wdata`  in  DATA_W  loader write data
- `ld_done`  out  1  one-cycle completion pulse to loader
- `d_req`  in  1  data-path request
- `d_we`  in  1  data-path write enable
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid with `d_done`, held until the next data read completes
- `d_done`  out  1  one-cycle completion pulse
- `i_req`  in  1  instruction-fetch request (read only)
- `i_addr`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetched instruction, valid with `i_done`, held until the next fetch completes
- `i_done`  out  1  one-cycle completion pulse
- `mem_addr`  out  ADDR_W  memory address
- `mem_we`  out  1  memory write strobe
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data; valid the cycle after the address is presented
- `busy`  out  1  high whenever FSM is not IDLE

## Operation
- States: IDLE, ACCESS, DONE. Encoding is free; only the listed behaviour is required.
- IDLE:
  - If any `*_req` is high, select an owner, latch its addr/we/wdata, and go to ACCESS.
  - Otherwise stay in IDLE.
- Owner selection:
  - Loader has strict priority.
  - Between data and instruction, use round-robin on a `last_data` flag: if both request, data wins when `last_data`=0, instruction wins when `last_data`=1.
  - A lone requester always wins.
  - `last_data` updates on every grant: 1 if the data port was granted, 0 if the instruction port was granted, unchanged if the loader was granted.
- ACCESS:
  - `mem_addr` = latched address.
  - `mem_we` = latched we, high for exactly this one cycle.
  - `mem_wdata` = latched wdata.
  - Always go to DONE.
- DONE:
  - Pulse the owner's `*_done` for this one cycle.
  - For a read by the data or instruction port, capture `mem_rdata` into that port's rdata register on this cycle's edge.
  - Go to IDLE.
- Latched request fields are immune to requester changes after the grant. Dropping `req` mid-transaction does not abort it; `done` still pulses.
- A requester must deassert or change `req` in the cycle after `done`. If `req` is still high in IDLE, it is treated as a new request.
- Loader reads complete normally, but no data is returned.
- `mem_addr` and `mem_wdata` hold their last values outside ACCESS. `mem_we` is 0 outside ACCESS.

## Timing
- Reset (async, `rst_n`=0):
  - State goes to IDLE.
  - All outputs are 0: `*_done`, `d_rdata`, `i_rdata`, `mem_addr`, `mem_we`, `mem_wdata`, `busy`.
  - `last_data` = 0.
  - An access in flight is abandoned with no `done`, and `mem_we` drops immediately.
- Latency for an uncontended access:
  - `req` sampled high in IDLE at edge t.
  - ACCESS during cycle t+1; memory write or read capture at edge t+2.
  - `done` high during cycle t+2; rdata visible from edge t+2 onward.
- Throughput: one access per 3 cycles. Back-to-back grants: IDLE is re-entered at t+3, so the next grant is sampled at edge t+3.
- `busy` is 1 during ACCESS and DONE. A waiting requester sees `busy`=1 while another port is served.
- Requests arriving in ACCESS or DONE are not sampled until IDLE.

## Test plan
- Reset mid-write: assert `d_req`, `d_we`=1, `d_addr`=5, `d_wdata`=0xDEADBEEF, then pull `rst_n` low during ACCESS -> `mem_we` falls to 0 immediately, no `d_done`, all outputs 0, `busy`=0.
- Loader fill then fetch: loader writes 0x20080007 to addr 0, then `i_req` with `i_addr`=0 -> `ld_done` 2 cycles after grant edge, `mem_we` high exactly 1 cycle; `i_done` pulses with `i_rdata`=0x20080007.
- Round-robin: `d_req` and `i_req` held high together for 4 transactions from reset -> grant order is data, instr, data, instr; each `done` is 3 cycles apart.
- Loader priority: `ld_req`, `d_req` and `i_req` all high in IDLE -> loader served first; then data (since `last_data`=0 is unchanged by the loader grant); then instr.
- Request drop: `i_req` high for one cycle only (granted), then low -> `i_done` still pulses at t+2 with correct data; FSM returns to IDLE and `busy`=0 at t+3.
- Read-data hold: data read of addr 3 (=0x11), then a data write of addr 3 = 0x22 -> `d_rdata` stays 0x11 through the write; the next data read of addr 3 returns 0x22.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter sharing one single-ported synchronous-read memory between
// the program loader, the data path and the instruction-fetch path.
module mem_port_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ld_req,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_wdata,
   output logic              ld_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   typedef enum logic [1:0] {OWN_LD, OWN_D, OWN_I} owner_t;

   state_t            state, state_nx;
   owner_t            owner, owner_nx;
   logic              lat_we, lat_we_nx;
   logic              last_data, last_data_nx;
   logic [ADDR_W-1:0] addr_q, addr_nx;
   logic [DATA_W-1:0] wdata_q, wdata_nx;
   logic [DATA_W-1:0] d_rdata_q, i_rdata_q;
   logic              rd_done;

   always_comb begin
      state_nx     = state;
      owner_nx     = owner;
      lat_we_nx    = lat_we;
      last_data_nx = last_data;
      addr_nx      = addr_q;
      wdata_nx     = wdata_q;
      case (state)
         IDLE: begin
            if (ld_req) begin
               owner_nx  = OWN_LD;
               lat_we_nx = ld_we;
               addr_nx   = ld_addr;
               wdata_nx  = ld_wdata;
               state_nx  = ACCESS;
            end else if (d_req && (!i_req || !last_data)) begin
               owner_nx     = OWN_D;
               lat_we_nx    = d_we;
               addr_nx      = d_addr;
               wdata_nx     = d_wdata;
               last_data_nx = 1'b1;
               state_nx     = ACCESS;
            end else if (i_req) begin
               // fetches are read-only; the write-data bus keeps its last value
               owner_nx     = OWN_I;
               lat_we_nx    = 1'b0;
               addr_nx      = i_addr;
               last_data_nx = 1'b0;
               state_nx     = ACCESS;
            end
         end
         ACCESS:  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= OWN_LD;
         lat_we    <= 1'b0;
         last_data <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         d_rdata_q <= '0;
         i_rdata_q <= '0;
      end else begin
         state     <= state_nx;
         owner     <= owner_nx;
         lat_we    <= lat_we_nx;
         last_data <= last_data_nx;
         addr_q    <= addr_nx;
         wdata_q   <= wdata_nx;
         if (rd_done && owner == OWN_D) d_rdata_q <= mem_rdata;
         if (rd_done && owner == OWN_I) i_rdata_q <= mem_rdata;
      end
   end

   assign rd_done = (state == DONE) && !lat_we;

   // read data is forwarded during DONE so it is valid alongside the done pulse
   assign d_rdata   = (rd_done && owner == OWN_D) ? mem_rdata : d_rdata_q;
   assign i_rdata   = (rd_done && owner == OWN_I) ? mem_rdata : i_rdata_q;
   assign ld_done   = (state == DONE) && (owner == OWN_LD);
   assign d_done    = (state == DONE) && (owner == OWN_D);
   assign i_done    = (state == DONE) && (owner == OWN_I);
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = (state == ACCESS) && lat_we;
   assign busy      = (state != IDLE);

endmodule
